// File: rtl/mul_controller_pkg.sv
// Shared definitions for the 4x4 multiplier controller: state encodings,
// datapath select constants and the state-to-control decode.
package mul_controller_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LD   = 3'd2,
        P_HH = 3'd3,
        P_HL = 3'd4,
        P_LH = 3'd5,
        P_LL = 3'd6,
        DONE = 3'd7
    } state_t;

    localparam logic SEL_LO   = 1'b0;
    localparam logic SEL_HI   = 1'b1;
    localparam logic FB_SHIFT = 1'b0;
    localparam logic FB_HOLD  = 1'b1;

    typedef struct packed {
        logic acc_clr;
        logic ld_1;
        logic ld_2;
        logic s0;
        logic s1;
        logic s2;
        logic busy;
        logic done;
    } ctrl_t;

    // Control word for a state; the partial-product order HH, HL, LH, LL lets
    // the accumulator be shifted by 2 before HL and LL and held before HH and LH.
    function automatic ctrl_t decode(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            CLR: begin
                c.acc_clr = 1'b1;
                c.busy    = 1'b1;
            end
            LD: begin
                c.ld_1 = 1'b1;
                c.busy = 1'b1;
            end
            P_HH: begin
                c.ld_2 = 1'b1;
                c.s0   = SEL_HI;
                c.s1   = SEL_HI;
                c.s2   = FB_HOLD;
                c.busy = 1'b1;
            end
            P_HL: begin
                c.ld_2 = 1'b1;
                c.s0   = SEL_HI;
                c.s1   = SEL_LO;
                c.s2   = FB_SHIFT;
                c.busy = 1'b1;
            end
            P_LH: begin
                c.ld_2 = 1'b1;
                c.s0   = SEL_LO;
                c.s1   = SEL_HI;
                c.s2   = FB_HOLD;
                c.busy = 1'b1;
            end
            P_LL: begin
                c.ld_2 = 1'b1;
                c.s0   = SEL_LO;
                c.s1   = SEL_LO;
                c.s2   = FB_SHIFT;
                c.busy = 1'b1;
            end
            DONE:    c.done = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mul_controller.sv
// Moore FSM sequencing the 2x2-multiplier/accumulator datapath through the four
// partial products of a 4x4 multiply, with a start/busy/done/ack handshake.
module mul_controller
    import mul_controller_pkg::*;
#(
    parameter int DONE_HOLD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic acc_clr,
    output logic ld_1,
    output logic ld_2,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic busy,
    output logic done
);

    state_t state;
    ctrl_t  ctrl;

    function automatic state_t next_state(input state_t cur, input logic go, input logic taken);
        state_t nxt;
        nxt = cur;
        case (cur)
            IDLE: if (go) nxt = CLR;
            CLR:  nxt = LD;
            LD:   nxt = P_HH;
            P_HH: nxt = P_HL;
            P_HL: nxt = P_LH;
            P_LH: nxt = P_LL;
            P_LL: nxt = DONE;
            DONE: begin
                if (DONE_HOLD != 0) begin
                    if (taken) nxt = go ? CLR : IDLE;
                end else begin
                    nxt = go ? CLR : IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    // Outputs are registered alongside the state, decoded from the state being
    // entered, so they always match the state register without any input path.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ctrl  <= '0;
        end else begin
            state <= next_state(state, start, ack);
            ctrl  <= decode(next_state(state, start, ack));
        end
    end

    assign acc_clr = ctrl.acc_clr;
    assign ld_1    = ctrl.ld_1;
    assign ld_2    = ctrl.ld_2;
    assign s0      = ctrl.s0;
    assign s1      = ctrl.s1;
    assign s2      = ctrl.s2;
    assign busy    = ctrl.busy;
    assign done    = ctrl.done;

endmodule
